ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 216 +++++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage -- EX stage ALU plus the EX/MEM pipeline register.
//
// Purpose: computes the ALU result for the instruction in ID/EX and registers
// it, together with the write register and memory/writeback controls, into
// EX/MEM. MUL (op 12) is handled by a 32-step shift-add multiplier. The
// multiplier holds the ID/EX register via EX_Busy while it runs.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   EX_ALUOp[3:0]           ALU operation
//   EX_D1/EX_D2/EX_IMM      operand A, register operand B, immediate
//   EX_RD/EX_RT             destination register candidates
//   EX_RegWrite..EX_Valid   ID/EX controls (EX_Valid=0 is a bubble)
//   MEM_Stall               downstream hold of EX/MEM
//   EX_Flush                synchronous kill of the EX stage
//   EX_Busy                 combinational: upstream must hold ID/EX
//   MEM_*                   registered EX/MEM outputs
module ex_mem_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  EX_ALUOp,
    input  logic [31:0] EX_D1,
    input  logic [31:0] EX_D2,
    input  logic [31:0] EX_IMM,
    input  logic [4:0]  EX_RD,
    input  logic [4:0]  EX_RT,
    input  logic        EX_RegWrite,
    input  logic        EX_MemToReg,
    input  logic        EX_MEM_WEN,
    input  logic        EX_MEM_REN,
    input  logic        EX_RegDst,
    input  logic        EX_ALUSrc,
    input  logic        EX_Valid,
    input  logic        MEM_Stall,
    input  logic        EX_Flush,
    output logic        EX_Busy,
    output logic [31:0] MEM_ALUOut,
    output logic [31:0] MEM_StoreData,
    output logic [4:0]  MEM_WReg,
    output logic        MEM_RegWrite,
    output logic        MEM_MemToReg,
    output logic        MEM_MEM_WEN,
    output logic        MEM_MEM_REN,
    output logic        MEM_Valid
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_alu;
    logic [4:0]  w_wreg;
    logic        w_is_mul;

    // FSM decode outputs
    logic        w_ld_bubble;
    logic        w_ld_alu;
    logic        w_ld_mul;
    logic        w_start;
    logic        w_step;

    // Multiplier datapath and the MUL instruction's captured side-band
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [4:0]  r_cnt;
    logic [31:0] r_sd;
    logic [4:0]  r_wreg;
    logic        r_rw;
    logic        r_m2r;
    logic        r_wen;
    logic        r_ren;

    assign w_a      = EX_D1;
    assign w_b      = EX_ALUSrc ? EX_IMM : EX_D2;
    assign w_wreg   = EX_RegDst ? EX_RD : EX_RT;
    assign w_is_mul = (EX_ALUOp == OP_MUL);

    always_comb begin
        w_alu = 32'd0;
        case (EX_ALUOp)
            OP_ADD:  w_alu = w_a + w_b;
            OP_SUB:  w_alu = w_a - w_b;
            OP_AND:  w_alu = w_a & w_b;
            OP_OR:   w_alu = w_a | w_b;
            OP_XOR:  w_alu = w_a ^ w_b;
            OP_NOR:  w_alu = ~(w_a | w_b);
            OP_SLT:  w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
            OP_SLTU: w_alu = {31'd0, w_a < w_b};
            OP_SLL:  w_alu = w_a << w_b[4:0];
            OP_SRL:  w_alu = w_a >> w_b[4:0];
            OP_SRA:  w_alu = $unsigned($signed(w_a) >>> w_b[4:0]);
            OP_LUI:  w_alu = w_b << 16;
            default: w_alu = 32'd0;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        w_next = r_state;
        if (EX_Flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (!MEM_Stall && EX_Valid && w_is_mul) w_next = S_MUL;
                S_MUL:   if (r_cnt == 5'd31) w_next = S_DONE;
                S_DONE:  if (!MEM_Stall) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Output decode. EX_Busy is gated by reset so it reads 0 while reset is
    // held even if a MUL is sitting in ID/EX.
    always_comb begin
        w_ld_bubble = EX_Flush || (r_state == S_IDLE && !MEM_Stall && !EX_Valid);
        w_ld_alu    = !EX_Flush && r_state == S_IDLE && !MEM_Stall && EX_Valid && !w_is_mul;
        w_start     = !EX_Flush && r_state == S_IDLE && !MEM_Stall && EX_Valid && w_is_mul;
        w_ld_mul    = !EX_Flush && r_state == S_DONE && !MEM_Stall;
        // Stepping ignores MEM_Stall; only flush stops it
        w_step      = !EX_Flush && r_state == S_MUL;
        EX_Busy     = !reset && ((r_state == S_MUL) ||
                      (r_state == S_IDLE && EX_Valid && w_is_mul && !EX_Flush));
    end

    // Shift-add multiplier. Operands and the instruction's side-band are
    // captured at the start edge so later ID/EX changes cannot leak in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mcand  <= 32'd0;
            r_mplier <= 32'd0;
            r_acc    <= 32'd0;
            r_cnt    <= 5'd0;
            r_sd     <= 32'd0;
            r_wreg   <= 5'd0;
            r_rw     <= 1'b0;
            r_m2r    <= 1'b0;
            r_wen    <= 1'b0;
            r_ren    <= 1'b0;
        end else if (w_start) begin
            r_mcand  <= w_a;
            r_mplier <= w_b;
            r_acc    <= 32'd0;
            r_cnt    <= 5'd0;
            r_sd     <= EX_D2;
            r_wreg   <= w_wreg;
            r_rw     <= EX_RegWrite && (w_wreg != 5'd0);
            r_m2r    <= EX_MemToReg;
            r_wen    <= EX_MEM_WEN;
            r_ren    <= EX_MEM_REN;
        end else if (w_step) begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : 32'd0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 5'd1;
        end
    end

    // EX/MEM register
    always_ff @(posedge clock or posedge reset) begin
        if (reset || w_ld_bubble) begin
            // reset is asynchronous via the sensitivity list; the bubble load
            // shares the same all-zero contents
            MEM_ALUOut    <= 32'd0;
            MEM_StoreData <= 32'd0;
            MEM_WReg      <= 5'd0;
            MEM_RegWrite  <= 1'b0;
            MEM_MemToReg  <= 1'b0;
            MEM_MEM_WEN   <= 1'b0;
            MEM_MEM_REN   <= 1'b0;
            MEM_Valid     <= 1'b0;
        end else if (w_ld_alu) begin
            MEM_ALUOut    <= w_alu;
            MEM_StoreData <= EX_D2;
            MEM_WReg      <= w_wreg;
            MEM_RegWrite  <= EX_RegWrite && (w_wreg != 5'd0);
            MEM_MemToReg  <= EX_MemToReg;
            MEM_MEM_WEN   <= EX_MEM_WEN;
            MEM_MEM_REN   <= EX_MEM_REN;
            MEM_Valid     <= 1'b1;
        end else if (w_ld_mul) begin
            MEM_ALUOut    <= r_acc;
            MEM_StoreData <= r_sd;
            MEM_WReg      <= r_wreg;
            MEM_RegWrite  <= r_rw;
            MEM_MemToReg  <= r_m2r;
            MEM_MEM_WEN   <= r_wen;
            MEM_MEM_REN   <= r_ren;
            MEM_Valid     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage -- self-checking bench for ex_mem_stage.
// Inputs are driven at posedge+1; combinational EX_Busy is sampled 1 time unit
// later, registered outputs after the following posedge.
module tb_ex_mem_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  EX_ALUOp;
    logic [31:0] EX_D1, EX_D2, EX_IMM;
    logic [4:0]  EX_RD, EX_RT;
    logic        EX_RegWrite, EX_MemToReg, EX_MEM_WEN, EX_MEM_REN;
    logic        EX_RegDst, EX_ALUSrc, EX_Valid, MEM_Stall, EX_Flush;
    logic        EX_Busy;
    logic [31:0] MEM_ALUOut, MEM_StoreData;
    logic [4:0]  MEM_WReg;
    logic        MEM_RegWrite, MEM_MemToReg, MEM_MEM_WEN, MEM_MEM_REN, MEM_Valid;

    ex_mem_stage dut (
        .clock(clock), .reset(reset), .EX_ALUOp(EX_ALUOp),
        .EX_D1(EX_D1), .EX_D2(EX_D2), .EX_IMM(EX_IMM),
        .EX_RD(EX_RD), .EX_RT(EX_RT),
        .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
        .EX_MEM_WEN(EX_MEM_WEN), .EX_MEM_REN(EX_MEM_REN),
        .EX_RegDst(EX_RegDst), .EX_ALUSrc(EX_ALUSrc), .EX_Valid(EX_Valid),
        .MEM_Stall(MEM_Stall), .EX_Flush(EX_Flush), .EX_Busy(EX_Busy),
        .MEM_ALUOut(MEM_ALUOut), .MEM_StoreData(MEM_StoreData),
        .MEM_WReg(MEM_WReg), .MEM_RegWrite(MEM_RegWrite),
        .MEM_MemToReg(MEM_MemToReg), .MEM_MEM_WEN(MEM_MEM_WEN),
        .MEM_MEM_REN(MEM_MEM_REN), .MEM_Valid(MEM_Valid)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  wreg;
        logic        rw, m2r, wen, ren, vld;
    } out_t;

    typedef struct packed {
        logic data_chk;
        out_t o;
    } sb_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] d1, d2, imm;
        logic [4:0]  rd, rt;
        logic        rw, m2r, wen, ren, rdst, asrc, vld;
        logic [31:0] e_alu;
    } vec_t;

    sb_t  sb[$];
    vec_t vt[20];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] d1, d2, imm,
                                input logic [4:0] rd, rt, input logic rw, m2r, wen, ren,
                                input logic rdst, asrc, vld, input logic [31:0] e_alu);
        vec_t v;
        v.op = op; v.d1 = d1; v.d2 = d2; v.imm = imm; v.rd = rd; v.rt = rt;
        v.rw = rw; v.m2r = m2r; v.wen = wen; v.ren = ren; v.rdst = rdst;
        v.asrc = asrc; v.vld = vld; v.e_alu = e_alu;
        return v;
    endfunction

    function automatic sb_t exp_of(input vec_t v);
        sb_t s;
        logic [4:0] w;
        w = v.rdst ? v.rd : v.rt;
        s = '0;
        s.data_chk = v.vld;
        if (v.vld) begin
            s.o.alu = v.e_alu; s.o.sd = v.d2; s.o.wreg = w;
            s.o.rw = v.rw && (w != 5'd0);
            s.o.m2r = v.m2r; s.o.wen = v.wen; s.o.ren = v.ren; s.o.vld = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic out_t get_out();
        out_t o;
        o.alu = MEM_ALUOut; o.sd = MEM_StoreData; o.wreg = MEM_WReg;
        o.rw = MEM_RegWrite; o.m2r = MEM_MemToReg; o.wen = MEM_MEM_WEN;
        o.ren = MEM_MEM_REN; o.vld = MEM_Valid;
        return o;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input vec_t v);
        EX_ALUOp = v.op; EX_D1 = v.d1; EX_D2 = v.d2; EX_IMM = v.imm;
        EX_RD = v.rd; EX_RT = v.rt; EX_RegWrite = v.rw; EX_MemToReg = v.m2r;
        EX_MEM_WEN = v.wen; EX_MEM_REN = v.ren; EX_RegDst = v.rdst;
        EX_ALUSrc = v.asrc; EX_Valid = v.vld;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input out_t act, input out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got alu=%h sd=%h wreg=%0d ctl(rw,m2r,wen,ren,vld)=%b%b%b%b%b, want alu=%h sd=%h wreg=%0d ctl=%b%b%b%b%b",
                     nm, act.alu, act.sd, act.wreg, act.rw, act.m2r, act.wen, act.ren, act.vld,
                     exp.alu, exp.sd, exp.wreg, exp.rw, exp.m2r, exp.wen, exp.ren, exp.vld);
        end
    endtask

    task automatic check_sb(input string nm);
        sb_t  e;
        out_t a;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: scoreboard empty, got %h want an entry", nm, get_out());
            return;
        end
        e = sb.pop_front();
        a = get_out();
        if (!e.data_chk) begin
            a.alu = '0; a.sd = '0; a.wreg = '0;
        end
        chk_out(nm, a, e.o);
    endtask

    // Runs a MUL from cycle 0 through the last busy cycle, checking EX_Busy
    // and that EX/MEM stays put. Operands on the bus are scrambled after
    // edge 0. Optional stall window inside the MUL stepping.
    task automatic run_mul(input vec_t v, input string nm, input int st_lo, input int st_hi);
        out_t s0;
        drive(v);
        sb.push_back(exp_of(v));
        #1;
        chk({nm, "_busy0"}, {31'd0, EX_Busy}, 32'd1);
        s0 = get_out();
        tick();
        for (int c = 1; c <= 32; c++) begin
            EX_D1 = $urandom; EX_D2 = $urandom; EX_IMM = $urandom;
            MEM_Stall = (c >= st_lo && c <= st_hi);
            #1;
            if (EX_Busy !== 1'b1) chk($sformatf("%s_busy%0d", nm, c), {31'd0, EX_Busy}, 32'd1);
            if (get_out() !== s0) chk_out($sformatf("%s_hold%0d", nm, c), get_out(), s0);
            tick();
        end
        MEM_Stall = 1'b0;
        n_vec++;   // aggregate busy/hold sweep counted once when clean
        chk_out({nm, "_hold_end"}, get_out(), s0);
    endtask

    vec_t v;
    out_t snap;

    initial begin
        vt[0]  = mk(4'd0,  32'd5,        32'd7,        32'd0,      5'd3, 5'd0, 1,0,0,0, 1,0,1, 32'd12);
        vt[1]  = mk(4'd10, 32'h80000000, 32'h11,       32'd4,      5'd9, 5'd0, 1,0,0,0, 0,1,1, 32'hF8000000);
        vt[2]  = mk(4'd1,  32'd10,       32'd3,        32'd0,      5'd4, 5'd0, 1,0,0,0, 1,0,1, 32'd7);
        vt[3]  = mk(4'd1,  32'd0,        32'd1,        32'd0,      5'd4, 5'd0, 1,0,0,0, 1,0,1, 32'hFFFFFFFF);
        vt[4]  = mk(4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'd0,      5'd5, 5'd0, 1,0,0,0, 1,0,1, 32'hF000F000);
        vt[5]  = mk(4'd3,  32'h0F0F0000, 32'h000000F0, 32'd0,      5'd6, 5'd0, 1,0,0,0, 1,0,1, 32'h0F0F00F0);
        vt[6]  = mk(4'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'd0,      5'd7, 5'd0, 1,0,0,0, 1,0,1, 32'hF0F00F0F);
        vt[7]  = mk(4'd5,  32'd0,        32'd0,        32'd0,      5'd7, 5'd0, 1,0,0,0, 1,0,1, 32'hFFFFFFFF);
        vt[8]  = mk(4'd6,  32'hFFFFFFFF, 32'd1,        32'd0,      5'd8, 5'd0, 1,0,0,0, 1,0,1, 32'd1);
        vt[9]  = mk(4'd7,  32'hFFFFFFFF, 32'd1,        32'd0,      5'd8, 5'd0, 1,0,0,0, 1,0,1, 32'd0);
        vt[10] = mk(4'd8,  32'd1,        32'h1F,       32'd0,      5'd2, 5'd0, 1,0,0,0, 1,0,1, 32'h80000000);
        vt[11] = mk(4'd8,  32'd3,        32'h21,       32'd0,      5'd2, 5'd0, 1,0,0,0, 1,0,1, 32'd6);
        vt[12] = mk(4'd9,  32'h80000000, 32'd4,        32'd0,      5'd2, 5'd0, 1,0,0,0, 1,0,1, 32'h08000000);
        vt[13] = mk(4'd11, 32'hAAAA5555, 32'h77,       32'h1234,   5'd0, 5'd12,1,0,0,0, 0,1,1, 32'h12340000);
        vt[14] = mk(4'd13, 32'd5,        32'd7,        32'd0,      5'd1, 5'd0, 1,0,0,0, 1,0,1, 32'd0);
        vt[15] = mk(4'd0,  32'hFFFFFFFF, 32'h5,        32'd2,      5'd0, 5'd8, 1,1,0,1, 0,1,1, 32'd1);
        vt[16] = mk(4'd0,  32'd100,      32'hDEADBEEF, 32'd8,      5'd0, 5'd9, 0,0,1,0, 0,1,1, 32'd108);
        vt[17] = mk(4'd0,  32'd1,        32'd2,        32'd0,      5'd3, 5'd0, 1,1,1,1, 1,0,0, 32'd0);
        vt[18] = mk(4'd15, 32'd9,        32'd9,        32'd0,      5'd1, 5'd0, 1,0,0,0, 1,0,1, 32'd0);
        vt[19] = mk(4'd10, 32'h40000000, 32'h22,       32'd0,      5'd1, 5'd0, 1,0,0,0, 1,0,1, 32'h10000000);

        MEM_Stall = 1'b0; EX_Flush = 1'b0;
        // Reset with a MUL on the bus: EX_Busy must still read 0
        drive(mk(4'd12, 32'd3, 32'd4, 32'd0, 5'd1, 5'd0, 1,0,0,0, 1,0,1, 32'd0));
        #1 reset = 1'b1;
        #2;
        chk("reset_busy", {31'd0, EX_Busy}, 32'd0);
        tick(); tick();
        chk_out("reset_out", get_out(), '0);
        chk("reset_busy2", {31'd0, EX_Busy}, 32'd0);
        reset = 1'b0;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 20; i++) begin
            drive(vt[i]);
            sb.push_back(exp_of(vt[i]));
            tick();
            check_sb($sformatf("vec%0d", i));
        end

        // Random ADD/SUB/XOR against a reference
        for (int i = 0; i < 8; i++) begin
            v = mk(4'(i % 3 == 2 ? 4 : i % 3), $urandom, $urandom, 32'd0,
                   5'($urandom_range(0, 31)), 5'd0, 1,0,0,0, 1,0,1, 32'd0);
            v.e_alu = alu_ref(v.op, v.d1, v.d2);
            drive(v);
            sb.push_back(exp_of(v));
            tick();
            check_sb($sformatf("rnd%0d", i));
        end

        // Stall in IDLE holds EX/MEM, then loads once released
        v = mk(4'd0, 32'd2, 32'd3, 32'd0, 5'd10, 5'd0, 1,0,0,0, 1,0,1, 32'd5);
        drive(v);
        MEM_Stall = 1'b1;
        #1 snap = get_out();
        tick();
        chk_out("idle_stall_hold", get_out(), snap);
        MEM_Stall = 1'b0;
        sb.push_back(exp_of(v));
        tick();
        check_sb("idle_stall_release");

        // MUL basic: busy cycles 0..32, not busy in DONE, product after edge 33
        run_mul(mk(4'd12, 32'h00010003, 32'h00020005, 32'd0, 5'd5, 5'd0, 1,0,0,0, 1,0,1, 32'h000B000F),
                "mul", 99, 99);
        EX_Valid = 1'b0;
        #1 chk("mul_done_busy", {31'd0, EX_Busy}, 32'd0);
        tick();
        check_sb("mul_result");

        // MUL with stall during stepping and for 3 cycles in DONE
        run_mul(mk(4'd12, 32'd7, 32'h55, 32'd6, 5'd0, 5'd11, 1,0,0,0, 0,1,1, 32'd42),
                "mulst", 5, 8);
        EX_Valid = 1'b0;
        snap = get_out();
        for (int c = 0; c < 3; c++) begin
            MEM_Stall = 1'b1;
            #1 chk($sformatf("mulst_done_busy%0d", c), {31'd0, EX_Busy}, 32'd0);
            tick();
            chk_out($sformatf("mulst_done_hold%0d", c), get_out(), snap);
        end
        MEM_Stall = 1'b0;
        tick();
        check_sb("mulst_result");

        // Flush at MUL step 10 aborts; following ADD 1+1 completes normally
        drive(mk(4'd12, 32'd9, 32'd9, 32'd0, 5'd6, 5'd0, 1,0,0,0, 1,0,1, 32'd0));
        for (int c = 0; c < 10; c++) tick();
        EX_Flush = 1'b1;
        sb.push_back('0);
        tick();
        EX_Flush = 1'b0;
        v = mk(4'd0, 32'd1, 32'd1, 32'd0, 5'd7, 5'd0, 1,0,0,0, 1,0,1, 32'd2);
        drive(v);
        #1 chk("flush_busy", {31'd0, EX_Busy}, 32'd0);
        check_sb("flush_bubble");
        sb.push_back(exp_of(v));
        tick();
        check_sb("flush_add");

        // Reset at MUL step 20: outputs clear at once, no late write
        drive(mk(4'd12, 32'd3, 32'd5, 32'd0, 5'd8, 5'd0, 1,0,0,0, 1,0,1, 32'd0));
        for (int c = 0; c < 20; c++) tick();
        #2 reset = 1'b1;
        #1;
        chk_out("midmul_reset_out", get_out(), '0);
        chk("midmul_reset_busy", {31'd0, EX_Busy}, 32'd0);
        tick();
        reset = 1'b0;
        v = mk(4'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd9, 5'd0, 1,0,0,0, 1,0,1, 32'd1);
        drive(v);
        sb.push_back(exp_of(v));
        tick();
        check_sb("post_reset_slt");
        v = mk(4'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd9, 5'd0, 1,0,0,0, 1,0,1, 32'd0);
        drive(v);
        sb.push_back(exp_of(v));
        tick();
        check_sb("post_reset_sltu");

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1);
    end

endmodule
